qmac_sequencer: RTL

Control sequencer for the quantized vector-multiply datapath (Quantize → MAC → Dequantize). It holds one input vector and one quantized weight vector in local buffers, streams them element by element into the datapath on `start_i`, then waits for the datapath's completion. It captures the dequantized result and reports it with a one-cycle done pulse. It sits between the host/testbench register interface and the datapath top.

---
 rtl/qmac_pkg.sv | 23 ++
 rtl/qmac_sequencer_if.sv | 26 ++
 rtl/qmac_vbuf.sv | 27 ++
 rtl/qmac_sequencer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/qmac_pkg.sv
// Shared types and defaults for the quantized-MAC sequencer.
// QMAC_SEQ_TIMEOUT_EN adds the ERR state used by the watchdog.
package qmac_pkg;

   localparam int DEF_VEC_LEN = 8;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_QW_W = 8;
   localparam int DEF_TIMEOUT_CYC = 64;

   localparam logic CFG_SEL_X = 1'b0;
   localparam logic CFG_SEL_W = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
`ifdef QMAC_SEQ_TIMEOUT_EN
      , ST_ERR
`endif
   } qmac_seq_state_t;

endpackage

// File: rtl/qmac_sequencer_if.sv
// Element stream from the sequencer to the datapath and its
// completion/result return path.
interface qmac_sequencer_if #(
   parameter int DATA_W = 32,
   parameter int QW_W = 8
);
   logic              dp_valid_o;
   logic              dp_first_o;
   logic              dp_last_o;
   logic [DATA_W-1:0] dp_x_o;
   logic [QW_W-1:0]   dp_w_o;
   logic              dp_done_i;
   logic [DATA_W-1:0] dp_result_i;

   modport master (
      output dp_valid_o, dp_first_o, dp_last_o,
      output dp_x_o, dp_w_o,
      input  dp_done_i, dp_result_i
   );

   modport slave (
      input  dp_valid_o, dp_first_o, dp_last_o,
      input  dp_x_o, dp_w_o,
      output dp_done_i, dp_result_i
   );
endinterface

// File: rtl/qmac_vbuf.sv
// Reset-to-zero vector register file: one write port and
// one combinational read port; out-of-range writes are dropped.
module qmac_vbuf #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we && int'(waddr) < DEPTH) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;
endmodule

// File: rtl/qmac_sequencer.sv
// Streams buffered x/weight vectors into the quantized MAC datapath.
// QMAC_SEQ_TIMEOUT_EN adds a WAIT watchdog, ERR state and err_o.
module qmac_sequencer
   import qmac_pkg::*;
#(
   parameter int VEC_LEN = DEF_VEC_LEN,
   parameter int DATA_W = DEF_DATA_W,
   parameter int QW_W = DEF_QW_W,
`ifdef QMAC_SEQ_TIMEOUT_EN
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
`endif
   localparam int ADDR_W = $clog2(VEC_LEN)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cfg_we_i,
   input  logic              cfg_sel_i,
   input  logic [ADDR_W-1:0] cfg_addr_i,
   input  logic [DATA_W-1:0] cfg_data_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] result_o,
`ifdef QMAC_SEQ_TIMEOUT_EN
   output logic              err_o,
`endif
   qmac_sequencer_if.master  dp
);
   qmac_seq_state_t   state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [DATA_W-1:0] result_q;
   logic [DATA_W-1:0] x_rd;
   logic [QW_W-1:0]   w_rd;
   logic              idle, issue, last, wr_x, wr_w;

   assign idle  = (state_q == ST_IDLE);
   assign issue = (state_q == ST_ISSUE);
   assign last  = (idx_q == ADDR_W'(VEC_LEN - 1));
   assign wr_x  = idle & cfg_we_i & (cfg_sel_i == CFG_SEL_X);
   assign wr_w  = idle & cfg_we_i & (cfg_sel_i == CFG_SEL_W);

   qmac_vbuf #(.DEPTH(VEC_LEN), .WIDTH(DATA_W)) u_xbuf (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .we    (wr_x),
      .waddr (cfg_addr_i),
      .wdata (cfg_data_i),
      .raddr (idx_q),
      .rdata (x_rd)
   );

   qmac_vbuf #(.DEPTH(VEC_LEN), .WIDTH(QW_W)) u_wbuf (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .we    (wr_w),
      .waddr (cfg_addr_i),
      .wdata (cfg_data_i[QW_W-1:0]),
      .raddr (idx_q),
      .rdata (w_rd)
   );

`ifdef QMAC_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wdog_q;
   logic            err_q;
   logic            wd_hit;

   assign wd_hit = (wdog_q == WD_W'(TIMEOUT_CYC - 1));
   assign err_o  = err_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wdog_q <= (state_q == ST_WAIT) ? wdog_q + WD_W'(1) : '0;
         if (idle && start_i) err_q <= 1'b0;
         else if (state_d == ST_ERR && state_q == ST_WAIT) err_q <= 1'b1;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_ISSUE;
               idx_d   = '0;
            end
         end
         ST_ISSUE: begin
            if (last) begin
               state_d = ST_WAIT;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + ADDR_W'(1);
            end
         end
         ST_WAIT: begin
            if (dp.dp_done_i) state_d = ST_DONE;
`ifdef QMAC_SEQ_TIMEOUT_EN
            else if (wd_hit) state_d = ST_ERR;
`endif
         end
         ST_DONE: state_d = ST_IDLE;
`ifdef QMAC_SEQ_TIMEOUT_EN
         ST_ERR: state_d = ST_IDLE;
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (state_q == ST_WAIT && dp.dp_done_i) result_q <= dp.dp_result_i;
      end
   end

   // Outputs decode from the state register so reset drops them at once.
   assign busy_o   = ~idle;
`ifdef QMAC_SEQ_TIMEOUT_EN
   assign done_o   = (state_q == ST_DONE) | (state_q == ST_ERR);
`else
   assign done_o   = (state_q == ST_DONE);
`endif
   assign result_o = result_q;

   assign dp.dp_valid_o = issue;
   assign dp.dp_first_o = issue & (idx_q == '0);
   assign dp.dp_last_o  = issue & last;
   assign dp.dp_x_o     = issue ? x_rd : '0;
   assign dp.dp_w_o     = issue ? w_rd : '0;
endmodule
